// File: rtl/rr_burst_arbiter_pkg.sv
// rr_burst_arbiter_pkg: shared index-width helper and arbiter state encoding
package rr_burst_arbiter_pkg;

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_burst_arbiter_pick.sv
// rr_pick: combinational circular priority picker, first set req at or after prio
module rr_pick import rr_burst_arbiter_pkg::*; #(
   parameter int N = 4,
   localparam int IDW = clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] prio,
   output logic           any,
   output logic [IDW-1:0] idx
);

   logic [IDW-1:0] c;

   // scan farthest offset first so the offset nearest prio is written last and wins
   always_comb begin
      any = |req;
      idx = '0;
      c = '0;
      for (int k = N - 1; k >= 0; k--) begin
         c = IDW'((int'(prio) + k) % N);
         if (req[c]) idx = c;
      end
   end

endmodule

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: round-robin burst-locked arbiter feeding one registered valid/ready slice
module rr_burst_arbiter import rr_burst_arbiter_pkg::*; #(
   parameter int N = 4,
   parameter int DW = 32,
   localparam int IDW = clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    up_valid,
   input  logic [N*DW-1:0] up_data,
   input  logic [N-1:0]    up_last,
   output logic [N-1:0]    up_ready,
   output logic            down_valid,
   output logic [DW-1:0]   down_data,
   output logic            down_last,
   output logic [IDW-1:0]  down_id,
   input  logic            down_ready
);

   state_t         state, state_n;
   logic [IDW-1:0] prio, prio_n, gnt, gnt_n, w, sel;
   logic           any, slot_free, accept, last;

   rr_pick #(.N(N)) u_pick (
      .req  (up_valid),
      .prio (prio),
      .any  (any),
      .idx  (w)
   );

   // ready depends only on register state and the pick, never on this cycle's accept
   always_comb begin
      slot_free = !down_valid || down_ready;
      sel = (state == LOCK) ? gnt : w;
      up_ready = (rst && slot_free && (state == LOCK || any)) ? N'(1) << sel : '0;
      accept = |(up_valid & up_ready);
      last = up_last[sel];
      state_n = state;
      prio_n = prio;
      gnt_n = gnt;
      if (accept && last) begin
         state_n = IDLE;
         prio_n = (sel == IDW'(N - 1)) ? '0 : sel + 1'b1;
      end else if (accept) begin
         state_n = LOCK;
         gnt_n = sel;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         prio <= '0;
         gnt <= '0;
      end else begin
         state <= state_n;
         prio <= prio_n;
         gnt <= gnt_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         down_valid <= 1'b0;
         down_data <= '0;
         down_last <= 1'b0;
         down_id <= '0;
      end else if (slot_free) begin
         down_valid <= accept;
         if (accept) begin
            down_data <= up_data[sel*DW +: DW];
            down_last <= last;
            down_id <= sel;
         end
      end
   end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb_rr_burst_arbiter: directed vectors with hand-computed grants for rr_burst_arbiter
module tb_rr_burst_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [3:0]   up_valid = '0;
   logic [127:0] up_data = '0;
   logic [3:0]   up_last = '0;
   logic [3:0]   up_ready;
   logic         down_valid;
   logic [31:0]  down_data;
   logic         down_last;
   logic [1:0]   down_id;
   logic         down_ready = 1'b1;
   int           n_chk = 0;
   int           n_fail = 0;

   rr_burst_arbiter #(.N(4), .DW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .up_last    (up_last),
      .up_ready   (up_ready),
      .down_valid (down_valid),
      .down_data  (down_data),
      .down_last  (down_last),
      .down_id    (down_id),
      .down_ready (down_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input string tag, input logic [1:0] id, input logic [31:0] data, input logic lst);
      cyc();
      check({tag, "_valid"}, 32'(down_valid), 1);
      check({tag, "_id"}, 32'(down_id), 32'(id));
      check({tag, "_data"}, down_data, data);
      check({tag, "_last"}, 32'(down_last), 32'(lst));
   endtask

   initial begin
      for (int i = 0; i < 4; i++) up_data[i*32 +: 32] = 32'h10 + i;
      up_valid = 4'b1111;
      up_last = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("rst_dvalid", 32'(down_valid), 0);
         check("rst_uready", 32'(up_ready), 0);
      end
      rst = 1'b1;
      #1;
      check("rel_uready", 32'(up_ready), 32'b0001);
      for (int k = 0; k < 5; k++) beat("rr", 2'(k % 4), 32'h10 + k % 4, 1'b1);
      up_valid = 4'b0000;
      cyc();
      check("idle_dvalid", 32'(down_valid), 0);

      up_valid = 4'b0110;
      up_last = 4'b0100;
      up_data[32 +: 32] = 32'hA0;
      up_data[64 +: 32] = 32'hB0;
      #1;
      check("b0_uready", 32'(up_ready), 32'b0010);
      beat("b0", 2'd1, 32'hA0, 1'b0);
      up_data[32 +: 32] = 32'hA1;
      #1;
      check("b1_uready", 32'(up_ready), 32'b0010);
      beat("b1", 2'd1, 32'hA1, 1'b0);
      up_data[32 +: 32] = 32'hA2;
      up_last = 4'b0110;
      #1;
      check("b2_uready", 32'(up_ready), 32'b0010);
      beat("b2", 2'd1, 32'hA2, 1'b1);
      up_valid = 4'b0100;
      #1;
      check("b3_uready", 32'(up_ready), 32'b0100);
      beat("b3", 2'd2, 32'hB0, 1'b1);

      up_valid = 4'b0000;
      cyc();
      up_valid = 4'b0001;
      up_last = 4'b1111;
      up_data[0 +: 32] = 32'h55;
      beat("bp0", 2'd0, 32'h55, 1'b1);
      down_ready = 1'b0;
      up_valid = 4'b0010;
      up_data[32 +: 32] = 32'h66;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("bp_uready", 32'(up_ready), 0);
         beat("bp_hold", 2'd0, 32'h55, 1'b1);
      end
      down_ready = 1'b1;
      #1;
      check("bp_rel_uready", 32'(up_ready), 32'b0010);
      beat("bp1", 2'd1, 32'h66, 1'b1);

      up_valid = 4'b0100;
      beat("w0", 2'd2, 32'hB0, 1'b1);
      up_valid = 4'b0101;
      #1;
      check("w1_uready", 32'(up_ready), 32'b0001);
      beat("w1", 2'd0, 32'h55, 1'b1);
      check("w2_uready", 32'(up_ready), 32'b0100);
      beat("w2", 2'd2, 32'hB0, 1'b1);
      up_valid = 4'b1000;
      beat("w3", 2'd3, 32'h13, 1'b1);
      up_valid = 4'b1001;
      #1;
      check("wrap_uready", 32'(up_ready), 32'b0001);
      beat("w4", 2'd0, 32'h55, 1'b1);

      up_valid = 4'b1000;
      up_last = 4'b0000;
      up_data[96 +: 32] = 32'hC0;
      beat("r0", 2'd3, 32'hC0, 1'b0);
      up_data[96 +: 32] = 32'hC1;
      beat("r1", 2'd3, 32'hC1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check("arst_dvalid", 32'(down_valid), 0);
      check("arst_uready", 32'(up_ready), 0);
      cyc();
      rst = 1'b1;
      up_valid = 4'b1001;
      up_last = 4'b1001;
      #1;
      check("post_uready", 32'(up_ready), 32'b0001);
      beat("post", 2'd0, 32'h55, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
